// File: rtl/generic_memory_lat_gnt.sv
// Behavioural single-port memory with configurable read latency
// and registered grant (always / LFSR random / periodic stall).
module generic_memory_lat_gnt #(
  parameter int          ADDR_WIDTH   = 12,
  parameter int          DATA_WIDTH   = 64,
  parameter int          BE_WIDTH     = DATA_WIDTH/8,
  parameter int          LATENCY      = 1,
  parameter int          GNT_MODE     = 0,
  parameter int          GNT_PROB_Q4  = 12,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          PERIOD       = 4,
  parameter int          STALL_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic [ADDR_WIDTH-1:0] A,
  output logic                  GNT,
  input  logic                  WEN,
  input  logic [BE_WIDTH*8-1:0] D,
  input  logic [BE_WIDTH-1:0]   BE,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  RVAL
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;
  localparam int LANES     = DATA_WIDTH/32;
  localparam int CW        = $clog2(PERIOD);
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  // Preload image: 32-bit lane k of word a holds the byte
  // address of that lane.
  function automatic logic [DATA_WIDTH-1:0] pat(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[32*k +: 32] = 32'(a) * 32'(BE_WIDTH) + 32'(4*k);
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bmask(
    input logic [BE_WIDTH-1:0] be
  );
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Storage keeps the XOR difference from the preload image,
  // so zeroed storage reads back as the preload pattern.
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  logic [DATA_WIDTH-1:0] vdat_q [LATENCY];
  logic                  vld_q  [LATENCY];

  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;

  logic                  acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] be_mask;
  logic [DATA_WIDTH-1:0] wr_word;

  assign acc     = ~CEN & gnt_q;
  assign rd_word = mem_q[A] ^ pat(A);
  assign be_mask = bmask(BE);
  assign wr_word = (rd_word & ~be_mask)
                 | (D & be_mask);

  // Grant source next state: LFSR, period counter, mode select
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
              lfsr_q[15:1]};
    cnt_d  = (cnt_q == CW'(PERIOD-1)) ? '0 : cnt_q + 1'b1;
    gnt_d  = 1'b1;
    case (GNT_MODE)
      1: gnt_d = {1'b0, lfsr_d[3:0]} < 5'(GNT_PROB_Q4);
      2: gnt_d = cnt_d >= CW'(STALL_CYCLES);
      default: gnt_d = 1'b1;
    endcase
  end

  // Grant state registers; GNT never sees the request inputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr_q <= SEED;
      cnt_q  <= '0;
      gnt_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
    end
  end

  // Array write on accepted write; untouched by reset
  always_ff @(posedge CLK) begin
    if (acc && !WEN) begin
      mem_q[A] <= wr_word ^ pat(A);
    end
  end

  // Response shift register; idle slots carry zero data
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k]  <= 1'b0;
        vdat_q[k] <= '0;
      end
    end else begin
      vld_q[0]  <= acc;
      vdat_q[0] <= (acc && WEN) ? rd_word : '0;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k]  <= vld_q[k-1];
        vdat_q[k] <= vdat_q[k-1];
      end
    end
  end

  assign GNT  = gnt_q;
  assign RVAL = vld_q[LATENCY-1];
  assign Q    = vdat_q[LATENCY-1];

endmodule
